// File: rtl/axi_result_writer.sv
// axi_result_writer: AXI4 write master that drains the 512-bit result stream
// into memory as 4 KB-safe INCR bursts and pulses ctrl_done after the last B.
module axi_result_writer #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_MAX_BURST       = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [63:0]               ctrl_xfer_size_in_bytes,
  output logic                      ctrl_done,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  localparam int unsigned BEAT_W = 58;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned PTR_W  = $clog2(C_MAX_OUTSTANDING);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [C_ADDR_WIDTH-1:0] addr;
  logic [BEAT_W-1:0]       beats_rem;
  logic [BEAT_W-1:0]       issued;
  logic [BEAT_W-1:0]       acked;
  logic [LEN_W-1:0]        fifo_mem [C_MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [LEN_W-1:0]        wbeat;

  logic                    aw_fire, w_fire, w_pop, b_fire, w_active;
  logic [LEN_W-1:0]        aw_len, head_len, start_len, next_len;
  logic [C_ADDR_WIDTH-1:0] start_addr, n_addr;
  logic [BEAT_W-1:0]       start_beats, n_rem, n_issued, n_acked, n_out;
  logic [CNT_W-1:0]        n_fifo_cnt;

  // Beats of the next burst: limited by what is left, the burst cap and the 4 KB page
  function automatic logic [LEN_W-1:0] burst_len(input logic [5:0] page_beat,
                                                 input logic [BEAT_W-1:0] rem);
    logic [BEAT_W-1:0] n;
    logic [BEAT_W-1:0] room;
    room = BEAT_W'(7'd64 - {1'b0, page_beat});
    n = rem;
    if (n > BEAT_W'(C_MAX_BURST)) n = BEAT_W'(C_MAX_BURST);
    if (n > room) n = room;
    return LEN_W'(n);
  endfunction

  assign m_axi_awsize  = 3'd6;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_bready  = reset;

  // Handshakes, W pass-through and next-cycle bookkeeping values
  always_comb begin
    w_active    = (fifo_cnt != '0);
    head_len    = fifo_mem[rd_ptr];
    m_axi_wvalid  = s_axis_tvalid & w_active;
    s_axis_tready = m_axi_wready & w_active;
    m_axi_wlast   = w_active && (wbeat == head_len - LEN_W'(1));
    aw_fire = m_axi_awvalid & m_axi_awready;
    w_fire  = m_axi_wvalid & m_axi_wready;
    w_pop   = w_fire & m_axi_wlast;
    b_fire  = m_axi_bvalid & m_axi_bready;
    aw_len  = LEN_W'(m_axi_awlen) + LEN_W'(1);

    start_addr  = ctrl_addr_offset & ~C_ADDR_WIDTH'(63);
    start_beats = BEAT_W'(ctrl_xfer_size_in_bytes[63:6]) +
                  BEAT_W'(|ctrl_xfer_size_in_bytes[5:0]);
    start_len   = burst_len(start_addr[11:6], start_beats);

    n_addr = addr;
    n_rem  = beats_rem;
    if (aw_fire) begin
      n_addr = addr + C_ADDR_WIDTH'({aw_len, 6'b0});
      n_rem  = beats_rem - BEAT_W'(aw_len);
    end
    n_issued   = issued + BEAT_W'(aw_fire);
    n_acked    = acked + BEAT_W'(b_fire);
    n_out      = n_issued - n_acked;
    n_fifo_cnt = fifo_cnt + CNT_W'(aw_fire) - CNT_W'(w_pop);
    next_len   = burst_len(n_addr[11:6], n_rem);
  end

  // Burst-length FIFO storage, one entry per accepted AW
  always_ff @(posedge clk) begin
    if (aw_fire) fifo_mem[wr_ptr] <= aw_len;
  end

  // Command FSM, AW engine, W beat counter and completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      beats_rem     <= '0;
      issued        <= '0;
      acked         <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      wbeat         <= '0;
      ctrl_done     <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      if (aw_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (w_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= n_fifo_cnt;
      if (w_fire) wbeat <= w_pop ? '0 : wbeat + LEN_W'(1);
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            addr          <= start_addr;
            beats_rem     <= start_beats;
            issued        <= '0;
            acked         <= '0;
            m_axi_awvalid <= (start_beats != '0);
            m_axi_awaddr  <= start_addr;
            m_axi_awlen   <= (start_beats != '0) ? 8'(start_len) - 8'd1 : 8'd0;
            state         <= RUN;
          end
        end
        RUN: begin
          addr      <= n_addr;
          beats_rem <= n_rem;
          issued    <= n_issued;
          acked     <= n_acked;
          // Present the next burst once the current one is accepted (or none is pending)
          if (!m_axi_awvalid || aw_fire) begin
            m_axi_awvalid <= (n_rem != '0) && (n_out < BEAT_W'(C_MAX_OUTSTANDING));
            m_axi_awaddr  <= n_addr;
            m_axi_awlen   <= (n_rem != '0) ? 8'(next_len) - 8'd1 : 8'd0;
          end
          if ((n_rem == '0) && (n_fifo_cnt == '0) && (n_acked == n_issued)) begin
            ctrl_done     <= 1'b1;
            m_axi_awvalid <= 1'b0;
            issued        <= '0;
            acked         <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
